// File: rtl/multicycle_control.sv
// Multicycle CPU main control: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables and selects from the current state.
//
// state     | meaning
// FETCH     | read instruction, PC+4; waits on MemReady
// DECODE    | opcode dispatch, no datapath activity
// MEM_ADDR  | base + offset address for lw/sw
// MEM_READ  | data read; waits on MemReady
// MEM_WB    | load result to rt
// MEM_WRITE | data write; waits on MemReady
// EXEC_R    | register-register ALU op
// R_WB      | ALU result to rd
// EXEC_I    | register-immediate ALU op
// I_WB      | ALU result to rt
// JUMP      | PC <- jump target
// ILLEGAL   | one-cycle unsupported-opcode flag
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [3:0] State,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_fetch;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  state_t state_q;
  state_t state_n;
  ctl_t   ctl_q;
  logic   mem_ready;
  logic   fetch_go;

  assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] a;
    a = 3'b000;
    case (op)
      OP_ADDI: a = 3'b110;
      OP_ORI:  a = 3'b101;
      OP_ANDI: a = 3'b001;
      OP_LUI:  a = 3'b011;
      default: a = 3'b000;
    endcase
    return a;
  endfunction

  // Control word for the state being entered; the opcode is stable from
  // DECODE onward so EXEC_I/I_WB can latch their ALUOp on entry.
  function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_fetch  = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b010;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b010;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b111;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = 3'b111;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = imm_alu_op(op);
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = imm_alu_op(op);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:                        state_n = S_EXEC_R;
          OP_LW, OP_SW:                    state_n = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_n = S_EXEC_I;
          OP_J:                            state_n = S_JUMP;
          default:                         state_n = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_n = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_n = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_n = S_FETCH;
      S_EXEC_R:    state_n = S_R_WB;
      S_EXEC_I:    state_n = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_JUMP, S_ILLEGAL: state_n = S_FETCH;
      default:     state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctl_q   <= decode_ctl(S_FETCH, Opcode);
    end else begin
      state_q <= state_n;
      ctl_q   <= decode_ctl(state_n, Opcode);
    end
  end

  // Fetch completion is the only Mealy term; reset gates everything.
  assign fetch_go  = ctl_q.ir_fetch & mem_ready;

  assign PCWrite   = reset & (ctl_q.pc_write | fetch_go);
  assign IRWrite   = reset & fetch_go;
  assign IorD      = reset & ctl_q.iord;
  assign MemRead   = reset & ctl_q.mem_read;
  assign MemWrite  = reset & ctl_q.mem_write;
  assign MemtoReg  = reset & ctl_q.mem_to_reg;
  assign RegDst    = reset & ctl_q.reg_dst;
  assign RegWrite  = reset & ctl_q.reg_write;
  assign ALUSrcA   = reset & ctl_q.alu_src_a;
  assign ALUSrcB   = reset ? ctl_q.alu_src_b : 2'b00;
  assign PCSource  = reset ? ctl_q.pc_source : 2'b00;
  assign ALUOp     = reset ? ctl_q.alu_op : 3'b000;
  assign IllegalOp = reset & ctl_q.illegal;
  assign State     = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cycle table, a mid-cycle reset
// sequence, then random instruction streams against an instruction-plan model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic       IllegalOp;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .State(State), .IllegalOp(IllegalOp)
  );

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] BEQ = 6'b000100;

  int n_vec = 0;
  int n_bad = 0;

  logic [20:0] act;
  assign act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

  function automatic logic [2:0] iop(input logic [5:0] op);
    if (op == ADDI) return 3'b110;
    if (op == ORI)  return 3'b101;
    if (op == ANDI) return 3'b001;
    if (op == LUI)  return 3'b011;
    return 3'b000;
  endfunction

  // Expected outputs for a state code, straight from the per-state output list.
  function automatic logic [20:0] exp_out(input logic [3:0] st, input logic mr,
                                          input logic [5:0] op, input logic rst);
    logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    if (!rst) return '0;
    case (st)
      4'd0:  begin pcw = mr; irw = mr; mrd = 1; asb = 2'b01; aop = 3'b010; end
      4'd2:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 3'b111; end
      4'd7:  begin rw = 1; rdst = 1; aop = 3'b111; end
      4'd8:  begin asa = 1; asb = 2'b10; aop = iop(op); end
      4'd9:  begin rw = 1; asb = 2'b10; aop = iop(op); end
      4'd10: begin pcw = 1; pcs = 2'b10; end
      4'd11: ill = 1;
      default: ;
    endcase
    return {st, pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic check(input logic [20:0] e, input string tag);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, e);
    end
  endtask

  task automatic apply(input logic r, input logic [5:0] op, input logic m,
                       input logic [20:0] e, input string tag);
    @(posedge clk); #1;
    reset = r; Opcode = op; MemReady = m;
    @(negedge clk);
    check(e, tag);
  endtask

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic [5:0] op, input logic m, input logic [3:0] st);
    vec_t v;
    v.rst = r; v.op = op; v.mr = m; v.st = st;
    tbl.push_back(v);
  endtask

  // Random-phase model: an instruction is a list of state codes; FETCH,
  // MEM_READ and MEM_WRITE stall while MemReady is low.
  logic [3:0] plan[$];
  int         pidx;
  logic [5:0] cur_op;

  task automatic new_instr();
    logic [31:0] r;
    int sel;
    sel = $urandom_range(11);
    r = $urandom;
    case (sel)
      0: cur_op = RT;   1: cur_op = LW;   2: cur_op = SW;
      3: cur_op = ADDI; 4: cur_op = ANDI; 5: cur_op = ORI;
      6: cur_op = LUI;  7: cur_op = J;    8: cur_op = BEQ;
      default: cur_op = r[5:0];
    endcase
    plan.delete();
    plan.push_back(4'd0);
    plan.push_back(4'd1);
    if (cur_op == RT) begin plan.push_back(4'd6); plan.push_back(4'd7); end
    else if (cur_op == LW) begin plan.push_back(4'd2); plan.push_back(4'd3); plan.push_back(4'd4); end
    else if (cur_op == SW) begin plan.push_back(4'd2); plan.push_back(4'd5); end
    else if (cur_op inside {ADDI, ANDI, ORI, LUI}) begin plan.push_back(4'd8); plan.push_back(4'd9); end
    else if (cur_op == J) plan.push_back(4'd10);
    else plan.push_back(4'd11);
    pidx = 0;
  endtask

  initial begin
    logic m;
    reset = 1'b0; Opcode = RT; MemReady = 1'b1;

    add(0, RT, 1, 0);
    add(1, RT, 1, 0); add(1, RT, 1, 1); add(1, RT, 1, 6); add(1, RT, 1, 7);
    add(1, LW, 1, 0); add(1, LW, 1, 1); add(1, LW, 1, 2);
    add(1, LW, 0, 3); add(1, LW, 0, 3); add(1, LW, 1, 3); add(1, LW, 1, 4);
    add(1, ORI, 1, 0); add(1, ORI, 1, 1); add(1, ORI, 1, 8); add(1, ORI, 1, 9);
    add(1, LUI, 1, 0); add(1, LUI, 1, 1); add(1, LUI, 1, 8); add(1, LUI, 1, 9);
    add(1, J, 0, 0); add(1, J, 0, 0); add(1, J, 0, 0); add(1, J, 1, 0);
    add(1, J, 1, 1); add(1, J, 1, 10);
    add(1, BEQ, 1, 0); add(1, BEQ, 1, 1); add(1, BEQ, 1, 11);
    add(1, ADDI, 1, 0); add(1, ADDI, 0, 1); add(1, ADDI, 0, 8); add(1, ADDI, 0, 9);
    add(1, ANDI, 1, 0); add(1, ANDI, 1, 1); add(1, ANDI, 1, 8); add(1, ANDI, 1, 9);
    add(1, RT, 1, 0); add(1, RT, 0, 1); add(1, RT, 0, 6); add(1, RT, 0, 7);
    add(1, SW, 1, 0); add(1, SW, 1, 1); add(1, SW, 1, 2); add(1, SW, 0, 5); add(1, SW, 1, 5);
    add(1, SW, 1, 0); add(1, SW, 1, 1); add(1, SW, 1, 2); add(1, SW, 0, 5);
    add(0, SW, 0, 0);
    add(1, SW, 0, 0); add(1, SW, 1, 0); add(1, SW, 1, 1); add(1, SW, 1, 2); add(1, SW, 0, 5);
    add(0, RT, 1, 0);

    foreach (tbl[i])
      apply(tbl[i].rst, tbl[i].op, tbl[i].mr,
            exp_out(tbl[i].st, tbl[i].mr, tbl[i].op, tbl[i].rst), $sformatf("tbl%0d", i));

    // Reset asserted mid-cycle during a stalled store: outputs drop at once,
    // FETCH after the edge, no store once released.
    apply(1, SW, 1, exp_out(0, 1, SW, 1), "hs_fetch");
    apply(1, SW, 1, exp_out(1, 1, SW, 1), "hs_decode");
    apply(1, SW, 1, exp_out(2, 1, SW, 1), "hs_addr");
    apply(1, SW, 0, exp_out(5, 0, SW, 1), "hs_memwrite");
    #1 reset = 1'b0;
    #1 check('0, "hs_rst_immediate");
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check(exp_out(0, 0, SW, 1), "hs_after_release");

    new_instr();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m = ($urandom_range(3) != 0);
      apply(1, cur_op, m, exp_out(plan[pidx], m, cur_op, 1), "rand");
      n_vec++;
      if ((32'(RegWrite) + 32'(MemWrite) + 32'(PCWrite)) > 1) begin
        n_bad++;
        $display("FAIL excl: RegWrite=%b MemWrite=%b PCWrite=%b required at most one",
                 RegWrite, MemWrite, PCWrite);
      end
      if (!((plan[pidx] inside {4'd0, 4'd3, 4'd5}) && !m)) pidx++;
      if (pidx >= plan.size()) new_instr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_EN, default 1; when 0, MemReady is ignored and treated as constant 1.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port Opcode, input, 6, instruction opcode from the instruction register, stable from DECODE onward.
REQ-005 The block SHALL have port MemReady, input, 1, memory access complete in the current cycle.
REQ-006 The block SHALL have outputs PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, each 1 bit: datapath enables and selects.
REQ-007 The block SHALL have outputs ALUSrcB (2 bits), PCSource (2 bits) and ALUOp (3 bits); ALUOp feeds the ALU control decoder.
REQ-008 The block SHALL have outputs State (4 bits, current state code) and IllegalOp (1 bit, unsupported-opcode pulse).

Function
REQ-009 The block SHALL use state codes FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, JUMP=10, ILLEGAL=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-010 Outputs SHALL decode from State only (Moore), except IRWrite and PCWrite in FETCH, which SHALL equal MemReady.
REQ-011 Any output not listed for a state SHALL be 0, with ALUOp=000.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00; it holds until MemReady=1, then goes to DECODE.
REQ-013 DECODE SHALL drive all outputs 0 and branch on Opcode as follows.
- 000000 goes to EXEC_R.
- 100011 (lw) or 101011 (sw) goes to MEM_ADDR.
- 001000, 001100, 001101, 001111 go to EXEC_I.
- 000010 goes to JUMP.
- Any other opcode goes to ILLEGAL.
REQ-014 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=010; it goes to MEM_READ for lw and MEM_WRITE for sw.
REQ-015 MEM_READ SHALL drive MemRead=1, IorD=1; it holds until MemReady=1, then goes to MEM_WB.
REQ-016 MEM_WB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-017 MEM_WRITE SHALL drive MemWrite=1, IorD=1; it holds until MemReady=1, then goes to FETCH.
REQ-018 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=111, then go to R_WB; R_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, ALUOp=111, then go to FETCH.
REQ-019 EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp per opcode, then go to I_WB.
- addi: 110
- ori: 101
- andi: 001
- lui: 011
REQ-020 I_WB SHALL hold the EXEC_I ALUOp and ALUSrcB, drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-021 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-022 ILLEGAL SHALL drive IllegalOp=1 for exactly one cycle with no write enables, then go to FETCH.
REQ-023 With MemReady=1 constantly, latencies from FETCH entry to the next FETCH entry SHALL be:
- R-type: 4 cycles
- I-type: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- j: 3 cycles
- illegal: 3 cycles
REQ-024 Each cycle of MemReady=0 in FETCH, MEM_READ or MEM_WRITE SHALL add exactly one cycle, with outputs held.
REQ-025 MemReady SHALL be ignored in every other state.
REQ-026 RegWrite, MemWrite and PCWrite SHALL never be asserted in the same cycle.

Reset
REQ-027 A rising clk edge with reset=0 SHALL load State=FETCH, regardless of current state or pending memory wait.
REQ-028 While reset=0, all outputs SHALL be forced to 0 combinationally, including MemRead, PCWrite and ALUOp=000.
REQ-029 On the first edge with reset=1, the block SHALL start normal FETCH behaviour.

Verification
REQ-030 Reset, then Opcode=000000 with MemReady=1: State sequence SHALL be 0,1,6,7,0; R_WB SHALL show RegWrite=1, RegDst=1, ALUOp=111.
REQ-031 Opcode=100011, MemReady low 2 cycles in MEM_READ: State SHALL be 0,1,2,3,3,3,4,0; MEM_WB SHALL show MemtoReg=1, RegWrite=1.
REQ-032 Opcode=001101: EXEC_I and I_WB SHALL show ALUOp=101, ALUSrcB=10; Opcode=001111 SHALL show ALUOp=011.
REQ-033 MemReady=0 for 3 cycles in FETCH: IRWrite=PCWrite=0 during the wait, then 1 for exactly the MemReady=1 cycle.
REQ-034 Opcode=000100: State SHALL be 0,1,11,0 with a single IllegalOp pulse; Opcode=000010 SHALL give PCWrite=1, PCSource=10 in JUMP.
REQ-035 reset=0 asserted during MEM_WRITE with MemReady=0: all outputs 0 immediately, State=0 after the edge, and no MemWrite after release.
